// File: rtl/sillyvector_recorder_if.sv
// sillyvector_recorder_if: control, capture and read-back bundle
// master drives requests and vectors; slave is the recorder
interface sillyvector_recorder_if #(
  parameter int VW = 4,
  parameter int AW = 4
);
  logic          start;
  logic          stop;
  logic          in_valid;
  logic [VW-1:0] in_vec;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [VW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  logic          done;
  logic [AW:0]   count;
  logic          overflow;

  modport master (
    output start, stop, in_valid, in_vec,
    output rd_req, rd_addr,
    input  rd_data, rd_valid,
    input  busy, done, count, overflow
  );

  modport slave (
    input  start, stop, in_valid, in_vec,
    input  rd_req, rd_addr,
    output rd_data, rd_valid,
    output busy, done, count, overflow
  );
endinterface

// File: rtl/sillyvector_recorder.sv
// sillyvector_recorder: captures {inputs,expected} words into a table
// closed by a terminator word; optional RECORDER_DEDUP_EN drops repeats
module sillyvector_recorder #(
  parameter int            VW    = 4,
  parameter int            DEPTH = 11,
  parameter int            AW    = 4,
  parameter logic [VW-1:0] TERM  = 4'b1110
) (
  input logic                  clk,
  input logic                  reset,
  sillyvector_recorder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REC,
    S_TERM,
    S_DONE
  } state_e;

  localparam logic [AW:0] CMAX   = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] DEPTHW = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          rd_valid_q, rd_valid_d;
  logic [VW-1:0] rd_data_q, rd_data_d;

  logic          we;
  logic [AW-1:0] waddr;
  logic [VW-1:0] wdata;
  logic          dup;

  logic [VW-1:0] mem_q [DEPTH];

`ifdef RECORDER_DEDUP_EN
  logic [VW-1:0] last_q, last_d;
  logic          have_q, have_d;

  // track the last accepted vector; start forgets it
  always_comb begin
    last_d = last_q;
    have_d = have_q;
    if ((state_q == S_IDLE || state_q == S_DONE)
        && bus.start) begin
      have_d = 1'b0;
    end else if (state_q == S_REC && bus.in_valid
                 && !dup && count_q < CMAX) begin
      last_d = bus.in_vec;
      have_d = 1'b1;
    end
  end

  // dedup history registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q <= '0;
      have_q <= 1'b0;
    end else begin
      last_q <= last_d;
      have_q <= have_d;
    end
  end

  assign dup = have_q && (bus.in_vec == last_q);
`else
  assign dup = 1'b0;
`endif

  // recorder FSM: capture, overflow, terminator write
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    we         = 1'b0;
    waddr      = wr_ptr_q;
    wdata      = bus.in_vec;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d    = S_REC;
          wr_ptr_d   = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      S_REC: begin
        if (bus.in_valid && !dup) begin
          if (count_q < CMAX) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = count_q + (AW+1)'(1);
          end else begin
            overflow_d = 1'b1;
            state_d    = S_TERM;
          end
        end
        if (bus.stop) begin
          state_d = S_TERM;
        end
      end
      S_TERM: begin
        we      = 1'b1;
        wdata   = TERM;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // registered read port; out-of-range reads give zero
  always_comb begin
    rd_valid_d = bus.rd_req;
    rd_data_d  = rd_data_q;
    if (bus.rd_req) begin
      if ({1'b0, bus.rd_addr} < DEPTHW) begin
        rd_data_d = mem_q[bus.rd_addr];
      end else begin
        rd_data_d = '0;
      end
    end
  end

  // control and read-port state registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // table storage; never cleared, writes held off in reset
  always_ff @(posedge clk) begin
    if (reset && we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign bus.busy     = (state_q == S_REC) ||
                        (state_q == S_TERM);
  assign bus.done     = (state_q == S_DONE);
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_sillyvector_recorder.sv
// tb_sillyvector_recorder: vector table, directed corner cases,
// and random traffic against a queue-based reference model
module tb_sillyvector_recorder;

  localparam int VW    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 11;
  localparam logic [3:0] TERMW = 4'b1110;
`ifdef RECORDER_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sillyvector_recorder_if #(.VW(VW), .AW(AW)) bus ();

  sillyvector_recorder #(
    .VW(VW), .DEPTH(DEPTH), .AW(AW), .TERM(TERMW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model: 0 idle, 1 recording, 2 closing, 3 closed
  int         m_mode = 0;
  logic [3:0] m_q[$];
  bit         m_ovf = 0;
  logic [3:0] m_mem [16];
  bit         m_wr [16];
  bit         m_rdv = 0;
  logic [3:0] m_rdd = '0;
  bit         m_rdk = 1;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic model(input bit rs, st, sp, iv,
                       input logic [3:0] v,
                       input bit rq,
                       input logic [3:0] ra);
    bit dupv;
    if (!rs) begin
      m_mode = 0;
      m_q.delete();
      m_ovf = 0;
      m_rdv = 0;
      m_rdd = '0;
      m_rdk = 1;
      return;
    end
    m_rdv = rq;
    if (rq) begin
      if (int'(ra) >= DEPTH) begin
        m_rdd = '0;
        m_rdk = 1;
      end else begin
        m_rdd = m_mem[ra];
        m_rdk = m_wr[ra];
      end
    end
    case (m_mode)
      0, 3: if (st) begin
        m_mode = 1;
        m_q.delete();
        m_ovf = 0;
      end
      1: begin
        dupv = DEDUP && iv && m_q.size() > 0
               && v == m_q[$];
        if (iv && !dupv) begin
          if (m_q.size() < DEPTH - 1) begin
            m_mem[m_q.size()] = v;
            m_wr[m_q.size()] = 1;
            m_q.push_back(v);
          end else begin
            m_ovf = 1;
            m_mode = 2;
          end
        end
        if (sp) m_mode = 2;
      end
      2: begin
        m_mem[m_q.size()] = TERMW;
        m_wr[m_q.size()] = 1;
        m_mode = 3;
      end
      default: m_mode = 0;
    endcase
  endtask

  // one clock: drive, advance model, sample 1ns after edge
  task automatic step(input bit rs, st, sp, iv,
                      input logic [3:0] v,
                      input bit rq,
                      input logic [3:0] ra);
    reset        = rs;
    bus.start    = st;
    bus.stop     = sp;
    bus.in_valid = iv;
    bus.in_vec   = v;
    bus.rd_req   = rq;
    bus.rd_addr  = ra;
    model(rs, st, sp, iv, v, rq, ra);
    @(posedge clk);
    #1;
    chk("busy", int'(bus.busy),
        int'(m_mode == 1 || m_mode == 2));
    chk("done", int'(bus.done), int'(m_mode == 3));
    chk("count", int'(bus.count), m_q.size());
    chk("overflow", int'(bus.overflow), int'(m_ovf));
    chk("rd_valid", int'(bus.rd_valid), int'(m_rdv));
    if (m_rdk)
      chk("rd_data", int'(bus.rd_data), int'(m_rdd));
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 4'd0, 0, 4'd0);
  endtask

  task automatic rd(input logic [3:0] a);
    step(1, 0, 0, 0, 4'd0, 1, a);
  endtask

  typedef struct {
    bit         st, sp, iv;
    logic [3:0] v;
    bit         rq;
    logic [3:0] ra;
    bit         busy, done;
    int         cnt;
    bit         ovf, rdv;
    logic [3:0] rdd;
  } vec_t;

  vec_t tbl[$];

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = '0;
      m_wr[i]  = 0;
    end
    reset = 0;
    bus.start = 0; bus.stop = 0;
    bus.in_valid = 0; bus.in_vec = '0;
    bus.rd_req = 0; bus.rd_addr = '0;

    // recording of seven vectors, stop, then read-back
    tbl = '{
      '{1,0,0,4'b0000,0,4'd0, 1,0,0,0,0,4'b0000},
      '{0,0,1,4'b0001,0,4'd0, 1,0,1,0,0,4'b0000},
      '{0,0,1,4'b0010,0,4'd0, 1,0,2,0,0,4'b0000},
      '{0,0,1,4'b0100,0,4'd0, 1,0,3,0,0,4'b0000},
      '{0,0,1,4'b0111,0,4'd0, 1,0,4,0,0,4'b0000},
      '{0,0,1,4'b1000,0,4'd0, 1,0,5,0,0,4'b0000},
      '{0,0,1,4'b1011,0,4'd0, 1,0,6,0,0,4'b0000},
      '{0,0,1,4'b1101,0,4'd0, 1,0,7,0,0,4'b0000},
      '{0,1,0,4'b0000,0,4'd0, 1,0,7,0,0,4'b0000},
      '{0,0,0,4'b0000,0,4'd0, 0,1,7,0,0,4'b0000},
      '{0,0,0,4'b0000,1,4'd7, 0,1,7,0,1,4'b1110},
      '{0,0,0,4'b0000,1,4'd2, 0,1,7,0,1,4'b0100},
      '{0,0,0,4'b0000,1,4'd15,0,1,7,0,1,4'b0000},
      '{0,0,0,4'b0000,0,4'd0, 0,1,7,0,0,4'b0000}
    };

    step(0, 0, 0, 0, 4'd0, 0, 4'd0);
    step(0, 0, 0, 0, 4'd0, 0, 4'd0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_count", int'(bus.count), 0);
    chk("reset_rd_data", int'(bus.rd_data), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(1, tbl[i].st, tbl[i].sp, tbl[i].iv,
           tbl[i].v, tbl[i].rq, tbl[i].ra);
      chk($sformatf("t1_busy[%0d]", i),
          int'(bus.busy), int'(tbl[i].busy));
      chk($sformatf("t1_done[%0d]", i),
          int'(bus.done), int'(tbl[i].done));
      chk($sformatf("t1_count[%0d]", i),
          int'(bus.count), tbl[i].cnt);
      chk($sformatf("t1_ovf[%0d]", i),
          int'(bus.overflow), int'(tbl[i].ovf));
      chk($sformatf("t1_rdv[%0d]", i),
          int'(bus.rd_valid), int'(tbl[i].rdv));
      chk($sformatf("t1_rdd[%0d]", i),
          int'(bus.rd_data), int'(tbl[i].rdd));
    end

    // overflow: 12 distinct vectors back-to-back
    step(1, 1, 0, 0, 4'd0, 0, 4'd0);
    for (int i = 1; i <= 12; i++)
      step(1, 0, 0, 1, 4'(i), 0, 4'd0);
    idle();
    chk("t2_done", int'(bus.done), 1);
    chk("t2_count", int'(bus.count), 10);
    chk("t2_ovf", int'(bus.overflow), 1);
    rd(4'd10);
    chk("t2_term", int'(bus.rd_data), int'(TERMW));
    rd(4'd9);
    chk("t2_last", int'(bus.rd_data), 10);

    // stop with a vector in the same cycle
    step(1, 1, 0, 0, 4'd0, 0, 4'd0);
    step(1, 0, 0, 1, 4'b0001, 0, 4'd0);
    step(1, 0, 0, 1, 4'b0010, 0, 4'd0);
    step(1, 0, 1, 1, 4'b0110, 0, 4'd0);
    idle();
    chk("t3_count", int'(bus.count), 3);
    chk("t3_ovf", int'(bus.overflow), 0);
    rd(4'd2);
    chk("t3_mem2", int'(bus.rd_data), 4'b0110);
    rd(4'd3);
    chk("t3_mem3", int'(bus.rd_data), int'(TERMW));

    // reset in the middle of recording
    step(1, 1, 0, 0, 4'd0, 0, 4'd0);
    step(1, 0, 0, 1, 4'b0011, 0, 4'd0);
    step(1, 0, 0, 1, 4'b0101, 0, 4'd0);
    step(1, 0, 0, 1, 4'b1010, 0, 4'd0);
    step(0, 0, 0, 1, 4'b1111, 0, 4'd0);
    chk("t5_busy", int'(bus.busy), 0);
    chk("t5_count", int'(bus.count), 0);
    step(1, 1, 0, 0, 4'd0, 0, 4'd0);
    step(1, 0, 0, 1, 4'b1001, 0, 4'd0);
    step(1, 0, 1, 0, 4'd0, 0, 4'd0);
    idle();
    rd(4'd0);
    chk("t5_mem0", int'(bus.rd_data), 4'b1001);

    // repeated vector
    step(1, 1, 0, 0, 4'd0, 0, 4'd0);
    step(1, 0, 0, 1, 4'b0011, 0, 4'd0);
    step(1, 0, 0, 1, 4'b0011, 0, 4'd0);
    step(1, 0, 0, 1, 4'b0101, 0, 4'd0);
    step(1, 0, 1, 0, 4'd0, 0, 4'd0);
    idle();
    chk("t6_count", int'(bus.count), DEDUP ? 2 : 3);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 80) != 0,
           $urandom_range(0, 14) == 0,
           $urandom_range(0, 10) == 0,
           $urandom_range(0, 2) != 0,
           4'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
